// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and helpers for the cache-line to physical-memory burst adaptor.
package cacheline_adaptor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_LINE_WIDTH = 256;
    localparam int unsigned DEF_BUS_WIDTH  = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;

    // Byte address of a beat within a line; callers narrow the result to their address width.
    function automatic logic [63:0] beat_addr(input logic [63:0] base,
                                              input logic [31:0] beat,
                                              input logic [31:0] bus_bytes);
        return base + 64'(beat * bus_bytes);
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide data/mask register with a per-beat gather write port and a per-beat scatter read mux.
module line_beat_buffer
    import cacheline_adaptor_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned BUS_WIDTH  = DEF_BUS_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_load,
    input  logic [LINE_WIDTH-1:0]                         i_line,
    input  logic [LINE_WIDTH/8-1:0]                       i_mask,
    input  logic                                          i_slice_we,
    input  logic [$clog2(LINE_WIDTH/BUS_WIDTH)-1:0]       i_beat,
    input  logic [BUS_WIDTH-1:0]                          i_slice,
    input  logic [$clog2(LINE_WIDTH/BUS_WIDTH)-1:0]       i_sel,
    output logic [LINE_WIDTH-1:0]                         o_gathered_c,
    output logic [BUS_WIDTH-1:0]                          o_sel_data_c,
    output logic [BUS_WIDTH/8-1:0]                        o_sel_mask_c
);

    localparam int unsigned BUS_BYTES = BUS_WIDTH / 8;

    logic [LINE_WIDTH-1:0]   r_line;
    logic [LINE_WIDTH/8-1:0] r_mask;
    logic [LINE_WIDTH-1:0]   w_gathered;

    // Current line with the incoming beat merged in, so the final beat can go straight to the cache.
    always_comb begin
        w_gathered = r_line;
        if (i_slice_we) begin
            w_gathered[i_beat*BUS_WIDTH +: BUS_WIDTH] = i_slice;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
            r_mask <= '0;
        end else if (i_load) begin
            r_line <= i_line;
            r_mask <= i_mask;
        end else if (i_slice_we) begin
            r_line <= w_gathered;
        end
    end

    assign o_gathered_c = w_gathered;
    assign o_sel_data_c = r_line[i_sel*BUS_WIDTH +: BUS_WIDTH];
    assign o_sel_mask_c = r_mask[i_sel*BUS_BYTES +: BUS_BYTES];

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Converts one line-wide cache read/write into BEATS bus transfers, with a single-cycle completion pulse.
module cacheline_burst_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     ca_address,
    input  logic                      ca_read,
    input  logic                      ca_write,
    input  logic [LINE_WIDTH-1:0]     ca_wdata,
    input  logic [LINE_WIDTH/8-1:0]   ca_byte_enable,
    output logic [LINE_WIDTH-1:0]     ca_rdata,
    output logic                      ca_resp,
    output logic [ADDR_WIDTH-1:0]     pmem_address,
    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [BUS_WIDTH-1:0]      pmem_wdata,
    output logic [BUS_WIDTH/8-1:0]    pmem_byte_enable,
    input  logic [BUS_WIDTH-1:0]      pmem_rdata,
    input  logic                      pmem_resp
);

    localparam int unsigned BEATS      = LINE_WIDTH / BUS_WIDTH;
    localparam int unsigned BEAT_W     = $clog2(BEATS);
    localparam int unsigned BUS_BYTES  = BUS_WIDTH / 8;
    localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e                  r_state, w_state_nxt;
    logic [BEAT_W-1:0]       r_beat, w_beat_nxt, w_sel;
    logic [ADDR_WIDTH-1:0]   r_base, w_base_nxt, r_addr, w_addr_nxt, w_line_base;
    logic                    r_rd, w_rd_nxt, r_wr, w_wr_nxt, r_resp, w_resp_nxt;
    logic [BUS_WIDTH-1:0]    r_wdata, w_wdata_nxt, w_sel_data;
    logic [BUS_BYTES-1:0]    r_be, w_be_nxt, w_sel_mask;
    logic [LINE_WIDTH-1:0]   r_rdata, w_rdata_nxt, w_gathered;
    logic                    w_load, w_slice_we;

    assign w_line_base = ca_address & ~ADDR_WIDTH'(LINE_BYTES - 1);
    assign w_sel       = r_beat + BEAT_W'(1);

    line_beat_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_line       (ca_wdata),
        .i_mask       (ca_byte_enable),
        .i_slice_we   (w_slice_we),
        .i_beat       (r_beat),
        .i_slice      (pmem_rdata),
        .i_sel        (w_sel),
        .o_gathered_c (w_gathered),
        .o_sel_data_c (w_sel_data),
        .o_sel_mask_c (w_sel_mask)
    );

    // Next-state and next registered outputs; strobes stay high until the final acknowledge.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_base_nxt  = r_base;
        w_addr_nxt  = r_addr;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        w_resp_nxt  = 1'b0;
        w_wdata_nxt = r_wdata;
        w_be_nxt    = r_be;
        w_rdata_nxt = r_rdata;
        w_load      = 1'b0;
        w_slice_we  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ca_write || ca_read) begin
                    w_load     = 1'b1;
                    w_base_nxt = w_line_base;
                    w_addr_nxt = w_line_base;
                    w_beat_nxt = '0;
                    if (ca_write) begin
                        w_state_nxt = ST_WRITE;
                        w_wr_nxt    = 1'b1;
                        w_wdata_nxt = ca_wdata[BUS_WIDTH-1:0];
                        w_be_nxt    = ca_byte_enable[BUS_BYTES-1:0];
                    end else begin
                        w_state_nxt = ST_READ;
                        w_rd_nxt    = 1'b1;
                    end
                end
            end
            ST_READ, ST_WRITE: begin
                if (pmem_resp) begin
                    w_slice_we = (r_state == ST_READ);
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = ST_DONE;
                        w_beat_nxt  = '0;
                        w_rd_nxt    = 1'b0;
                        w_wr_nxt    = 1'b0;
                        w_resp_nxt  = 1'b1;
                        if (r_state == ST_READ) begin
                            w_rdata_nxt = w_gathered;
                        end
                    end else begin
                        w_beat_nxt = w_sel;
                        w_addr_nxt = ADDR_WIDTH'(beat_addr(64'(r_base), 32'(w_sel), BUS_BYTES));
                        if (r_state == ST_WRITE) begin
                            w_wdata_nxt = w_sel_data;
                            w_be_nxt    = w_sel_mask;
                        end
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_base  <= '0;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_resp  <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_base  <= w_base_nxt;
            r_addr  <= w_addr_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_resp  <= w_resp_nxt;
            r_wdata <= w_wdata_nxt;
            r_be    <= w_be_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign ca_rdata         = r_rdata;
    assign ca_resp          = r_resp;
    assign pmem_address     = r_addr;
    assign pmem_read        = r_rd;
    assign pmem_write       = r_wr;
    assign pmem_wdata       = r_wdata;
    assign pmem_byte_enable = r_be;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench: table-driven line transfers against a scoreboarded memory model, plus reset/spurious/parameter corners.
module tb_cacheline_burst_adaptor;

    localparam int unsigned LW    = 256;
    localparam int unsigned BW    = 32;
    localparam int unsigned BEATS = LW / BW;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     ca_address;
    logic            ca_read, ca_write;
    logic [LW-1:0]   ca_wdata;
    logic [LW/8-1:0] ca_byte_enable;
    logic [LW-1:0]   ca_rdata;
    logic            ca_resp;
    logic [31:0]     pmem_address;
    logic            pmem_read, pmem_write;
    logic [BW-1:0]   pmem_wdata;
    logic [BW/8-1:0] pmem_byte_enable;
    logic [BW-1:0]   pmem_rdata;
    logic            pmem_resp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cacheline_burst_adaptor #(.LINE_WIDTH(LW), .BUS_WIDTH(BW), .ADDR_WIDTH(32)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .ca_address       (ca_address),
        .ca_read          (ca_read),
        .ca_write         (ca_write),
        .ca_wdata         (ca_wdata),
        .ca_byte_enable   (ca_byte_enable),
        .ca_rdata         (ca_rdata),
        .ca_resp          (ca_resp),
        .pmem_address     (pmem_address),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } beat_t;

    typedef struct {
        string         name;
        logic          rd;
        logic          wr;
        logic          exp_wr;
        logic [31:0]   addr;
        logic [31:0]   base;
        logic [LW-1:0] wdata;
        logic [31:0]   be;
        int            stall_max;
        logic [31:0]   rseed;
    } vec_t;

    beat_t         sb_q[$];
    beat_t         sb_e;
    int            stall_left = 0, stall_max = 0, stall_total = 0, ack_cnt = 0, wr_high = 0;
    bit            spurious = 1'b0;
    logic [LW-1:0] rdata_model = '0;
    bit            sweep_go = 1'b0;

    // Memory model: drives pmem_resp/rdata for the next edge and checks each acknowledged beat.
    always @(negedge clk) begin
        pmem_resp = 1'b0;
        if (pmem_write) wr_high++;
        if (!rst && spurious) begin
            pmem_resp = 1'b1;
        end else if (!rst && (pmem_read || pmem_write)) begin
            if (stall_left > 0) begin
                stall_left--;
                stall_total++;
            end else if (sb_q.size() == 0) begin
                check("unexpected_beat", {pmem_read, pmem_write}, 2'b00);
            end else begin
                sb_e = sb_q.pop_front();
                check("beat_addr", pmem_address, sb_e.addr);
                check("beat_kind", {pmem_read, pmem_write}, {~sb_e.wr, sb_e.wr});
                if (sb_e.wr) begin
                    check("beat_wdata", pmem_wdata, sb_e.wdata);
                    check("beat_be", pmem_byte_enable, sb_e.be);
                end
                pmem_rdata = sb_e.rdata;
                pmem_resp  = 1'b1;
                ack_cnt++;
                stall_left = int'($urandom_range(32'(stall_max)));
            end
        end
    end

    task automatic push_beats(input vec_t v, inout logic [LW-1:0] line);
        beat_t e;
        for (int b = 0; b < int'(BEATS); b++) begin
            e.addr  = v.base + 32'(b * 4);
            e.wr    = v.exp_wr;
            e.wdata = v.wdata[b*32 +: 32];
            e.be    = v.be[b*4 +: 4];
            e.rdata = v.rseed + 32'(b);
            sb_q.push_back(e);
            if (!v.exp_wr) line[b*32 +: 32] = e.rdata;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic [LW-1:0] exp_line;
        exp_line = rdata_model;
        push_beats(v, exp_line);
        @(negedge clk);
        stall_max      = v.stall_max;
        stall_left     = int'($urandom_range(32'(v.stall_max)));
        stall_total    = 0;
        wr_high        = 0;
        ca_address     = v.addr;
        ca_read        = v.rd;
        ca_write       = v.wr;
        ca_wdata       = v.wdata;
        ca_byte_enable = v.be;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ca_resp && n < 300);
        check({v.name, "_resp_seen"}, ca_resp, 1'b1);
        check({v.name, "_latency"}, n, BEATS + stall_total);
        check({v.name, "_strobes_off"}, {pmem_read, pmem_write}, 2'b00);
        check({v.name, "_rdata"}, ca_rdata, exp_line);
        check({v.name, "_beats_left"}, sb_q.size(), 0);
        if (v.exp_wr) check({v.name, "_wr_held"}, wr_high, BEATS + stall_total);
        @(negedge clk);
        ca_read  = 1'b0;
        ca_write = 1'b0;
        @(posedge clk); #1;
        check({v.name, "_resp_one_cycle"}, ca_resp, 1'b0);
        sb_q.delete();
        rdata_model = exp_line;
    endtask

    localparam logic [LW-1:0] WD = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    // Reduced and wide configurations: zero-wait memory, back-to-back read then write.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int unsigned SLW = (g == 0) ? 128 : 512;
        localparam int unsigned SBW = (g == 0) ? 64 : 32;
        localparam int unsigned NB  = SLW / SBW;
        localparam int unsigned BB  = SBW / 8;

        logic [31:0]      s_addr, s_paddr, s_base;
        logic             s_rd, s_wr, s_resp, s_prd, s_pwr, s_presp;
        logic [SLW-1:0]   s_wdata, s_rdata, s_exp;
        logic [SLW/8-1:0] s_be;
        logic [SBW-1:0]   s_pwdata, s_prdata;
        logic [BB-1:0]    s_pbe;
        int               s_beat;
        bit               s_done;

        assign s_presp  = s_prd | s_pwr;
        assign s_prdata = SBW'({~s_paddr, s_paddr});

        cacheline_burst_adaptor #(.LINE_WIDTH(SLW), .BUS_WIDTH(SBW), .ADDR_WIDTH(32)) u_sdut (
            .clk              (clk),
            .rst              (rst),
            .ca_address       (s_addr),
            .ca_read          (s_rd),
            .ca_write         (s_wr),
            .ca_wdata         (s_wdata),
            .ca_byte_enable   (s_be),
            .ca_rdata         (s_rdata),
            .ca_resp          (s_resp),
            .pmem_address     (s_paddr),
            .pmem_read        (s_prd),
            .pmem_write       (s_pwr),
            .pmem_wdata       (s_pwdata),
            .pmem_byte_enable (s_pbe),
            .pmem_rdata       (s_prdata),
            .pmem_resp        (s_presp)
        );

        always @(negedge clk) begin
            if (!rst && (s_prd || s_pwr)) begin
                check($sformatf("sweep%0d_addr", g), s_paddr, s_base + 32'(s_beat * BB));
                if (s_pwr) begin
                    check($sformatf("sweep%0d_wdata", g), s_pwdata, s_wdata[(s_beat % NB)*SBW +: SBW]);
                    check($sformatf("sweep%0d_be", g), s_pbe, s_be[(s_beat % NB)*BB +: BB]);
                end
                s_beat++;
            end
        end

        initial begin
            int n;
            logic [31:0] a;
            s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0;
            s_done = 1'b0; s_beat = 0; s_base = '0; s_exp = '0;
            wait (sweep_go);
            for (int t = 0; t < 2; t++) begin
                @(negedge clk);
                s_base = (g == 0) ? 32'h0000_5A40 : 32'h0001_0C00;
                s_base = s_base + 32'(t * (SLW / 8));
                s_addr = s_base + 32'h5;
                s_beat = 0;
                if (t == 0) begin
                    s_rd = 1'b1;
                    for (int b = 0; b < int'(NB); b++) begin
                        a = s_base + 32'(b * BB);
                        s_exp[b*SBW +: SBW] = SBW'({~a, a});
                    end
                end else begin
                    for (int i = 0; i < int'(SLW / 32); i++) s_wdata[i*32 +: 32] = $urandom();
                    for (int i = 0; i < int'(SLW / 32); i++) s_be[i*4 +: 4] = 4'($urandom());
                    s_wr = 1'b1;
                end
                @(posedge clk);
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (!s_resp && n < 100);
                check($sformatf("sweep%0d_t%0d_latency", g, t), n, NB);
                check($sformatf("sweep%0d_t%0d_beats", g, t), s_beat, NB);
                check($sformatf("sweep%0d_t%0d_rdata", g, t), s_rdata, s_exp);
                @(negedge clk);
                s_rd = 1'b0;
                s_wr = 1'b0;
            end
            s_done = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   n;

        vecs[0] = '{"zero_wait_read", 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_1220, '0, 32'h0, 0, 32'h1000_0000};
        vecs[1] = '{"stalled_write", 1'b0, 1'b1, 1'b1, 32'h0000_2040, 32'h0000_2040, WD, 32'hF0F0_00FF, 3, 32'h0};
        vecs[2] = '{"rd_wr_together", 1'b1, 1'b1, 1'b1, 32'h0000_301F, 32'h0000_3000, ~WD, 32'hFFFF_FFFF, 1, 32'h0};
        vecs[3] = '{"stalled_read", 1'b1, 1'b0, 1'b0, 32'hABCD_EF7F, 32'hABCD_EF60, '0, 32'h0, 2, 32'hA5A5_0000};
        vecs[4] = '{"zero_wait_write", 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, WD, 32'h0000_FFFF, 0, 32'h0};

        rst = 1'b1; ca_address = '0; ca_read = 1'b0; ca_write = 1'b0;
        ca_wdata = '0; ca_byte_enable = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ca_rdata", ca_rdata, '0);
        check("rst_ca_resp", ca_resp, 1'b0);
        check("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_pmem_wdata", pmem_wdata, 32'h0);
        check("rst_pmem_be", pmem_byte_enable, 4'h0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset after beat 3 of a read: abort, zero ca_rdata, no completion.
        v = '{"aborted_read", 1'b1, 1'b0, 1'b0, 32'h0000_6000, 32'h0000_6000, '0, 32'h0, 0, 32'h5500_0000};
        push_beats(v, rdata_model);
        @(negedge clk);
        stall_max = 0; stall_left = 0; ack_cnt = 0;
        ca_address = v.addr; ca_read = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack_cnt < 4 && n < 50);
        rst = 1'b1;
        ca_read = 1'b0;
        @(posedge clk); #1;
        check("abort_strobes", {pmem_read, pmem_write}, 2'b00);
        check("abort_ca_rdata", ca_rdata, '0);
        check("abort_ca_resp", ca_resp, 1'b0);
        rst = 1'b0;
        sb_q.delete();
        rdata_model = '0;
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_no_resp", ca_resp, 1'b0);
        end
        v = '{"post_reset_read", 1'b1, 1'b0, 1'b0, 32'h4444_4444, 32'h4444_4440, '0, 32'h0, 1, 32'h7000_0000};
        run_vec(v);

        // Stray acknowledges while idle must not advance the beat counter.
        @(posedge clk); #1;
        spurious = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        spurious = 1'b0;
        check("spurious_idle_strobes", {pmem_read, pmem_write, ca_resp}, 3'b000);
        v = '{"after_spurious_read", 1'b1, 1'b0, 1'b0, 32'h0000_8008, 32'h0000_8000, '0, 32'h0, 0, 32'h3C00_0000};
        run_vec(v);

        sweep_go = 1'b1;
        n = 0;
        while (!(g_sweep[0].s_done && g_sweep[1].s_done) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("sweep_complete", {g_sweep[0].s_done, g_sweep[1].s_done}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
Parametrised line-to-bus adaptor between the cache's line-wide memory port and a narrower physical-memory port. A line read is gathered as a sequence of BEATS bus transfers into a line buffer. A line write is scattered from a latched copy of the line as BEATS bus transfers. The adaptor holds one outstanding request, generates per-beat addresses and byte enables, and returns a single-cycle completion pulse to the cache.

Parameters:
LINE_WIDTH, 256, cache line width in bits; multiple of BUS_WIDTH
BUS_WIDTH, 32, physical memory data width in bits; multiple of 8
ADDR_WIDTH, 32, byte address width
BEATS (derived), LINE_WIDTH/BUS_WIDTH, transfers per line; must be at least 2

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
ca_address  in  ADDR_WIDTH  line address from cache; low log2(LINE_WIDTH/8) bits ignored
ca_read  in  1  line read request; held until ca_resp
ca_write  in  1  line write request; held until ca_resp
ca_wdata  in  LINE_WIDTH  line write data
ca_byte_enable  in  LINE_WIDTH/8  per-byte write mask
ca_rdata  out  LINE_WIDTH  assembled read line
ca_resp  out  1  one-cycle completion pulse
pmem_address  out  ADDR_WIDTH  current beat byte address
pmem_read  out  1  beat read strobe
pmem_write  out  1  beat write strobe
pmem_wdata  out  BUS_WIDTH  current beat write data
pmem_byte_enable  out  BUS_WIDTH/8  current beat byte mask
pmem_rdata  in  BUS_WIDTH  beat read data, valid when pmem_resp=1
pmem_resp  in  1  per-beat acknowledge

Behaviour:
- Reset state: IDLE, beat counter 0, ca_rdata 0, ca_resp 0, pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0, pmem_byte_enable 0.
- Reset mid-transfer: abort on the next edge. Partial read data is discarded and ca_rdata is zeroed. No ca_resp is issued.
- States:
  - IDLE: accept a request.
    - ca_write=1 → WRITE. Write wins if ca_read and ca_write are both 1 (dirty-eviction priority).
    - Else ca_read=1 → READ.
    - On acceptance: latch the line-aligned base address, ca_wdata and ca_byte_enable; clear the beat counter.
  - READ: pmem_read=1.
    - pmem_address = base + beat*(BUS_WIDTH/8).
    - When pmem_resp=1: store pmem_rdata into buffer slice [beat*BUS_WIDTH +: BUS_WIDTH] and increment beat.
    - On the last beat's pmem_resp → DONE.
  - WRITE: pmem_write=1.
    - pmem_wdata and pmem_byte_enable are the beat-th slices of the latched line and mask.
    - Address rule is the same as READ.
    - Advance on pmem_resp. Last beat → DONE.
  - DONE: ca_resp=1 for exactly one cycle, then → IDLE. For reads, ca_rdata updates from the buffer in this cycle.
- Strobe handling:
  - pmem_read/pmem_write are registered and stay high across consecutive beats; they deassert on the cycle after the final pmem_resp.
  - pmem_resp while IDLE or DONE is ignored.
  - No fixed memory latency is assumed. Zero-wait memory (pmem_resp high every cycle) completes a line in BEATS cycles plus 1 cycle for DONE.
- Requests arriving during READ/WRITE/DONE are not sampled. Changes on ca_wdata or ca_address after acceptance have no effect.
- Write beats with an all-zero byte-enable slice are still issued; the mask is passed through unchanged.
- ca_rdata holds its last value between reads; writes do not modify it.
- Beat counter width is clog2(BEATS). It wraps to 0 after the last beat.
- Total write latency is BEATS beats plus 1 cycle from acceptance to ca_resp; read latency is the same.

Decomposition:
- Shared package cacheline_adaptor_pkg:
  - state enum (IDLE, READ, WRITE, DONE)
  - default LINE_WIDTH/BUS_WIDTH constants
  - beat-address helper function
- Sub-module line_beat_buffer:
  - LINE_WIDTH register with a per-beat slice write port (read gather)
  - per-beat slice select mux (write scatter, data and mask)
  - indexed by the beat counter from the top-level FSM

Test Plan:
- Zero-wait read at ca_address=0x0000_1234 (line-aligned 0x0000_1220), memory returning 0x1000_0000+beat:
  - required pmem_address sequence 0x1220, 0x1224 … 0x123C
  - ca_rdata = {0x10000007 … 0x10000000}
  - ca_resp pulses exactly 9 cycles after acceptance
- Write with ca_wdata = 256'h0123…CDEF, ca_byte_enable = 32'hF0F0_00FF, random 0–3-cycle pmem_resp stalls:
  - each beat's pmem_wdata and pmem_byte_enable match the slice (beat0 mask 4'hF, beat1 4'hF, beat2 4'h0, …)
  - pmem_write stays high across stalls
  - exactly 8 acknowledged beats, one ca_resp
- ca_read and ca_write asserted together → WRITE path only, and ca_rdata unchanged.
- rst asserted after beat 3 of a read → next cycle all pmem strobes 0, ca_rdata 0, no ca_resp. A following read completes normally.
- Spurious pmem_resp pulses in IDLE, then a read → beat counter starts at 0 and data lands in the correct slices.
- Parameter sweep: LINE_WIDTH=128/BUS_WIDTH=64 (2 beats) and LINE_WIDTH=512/BUS_WIDTH=32 (16 beats) → back-to-back read-then-write completes with correct addresses and the counter wraps cleanly.
